// File: rtl/perf_counter_mmio.sv
// Cache performance counters (read miss, write miss, writeback, cycles) exposed to the
// CPU as a 16-byte memory-mapped window with a mem_read/mem_write/mem_resp handshake.
`timescale 1ns/1ps
module perf_counter_mmio #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cache_read,
    input  logic        cache_write,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic        dbg_state_o
);

    // Handshake: a request is accepted in IDLE when sel is high; mem_resp pulses for
    // exactly the following cycle (RESP), during which no new request is accepted.
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

    state_e      state_q, state_d;
    logic        pr_q, pw_q;
    logic        freeze_q, freeze_d;
    logic [15:0] ctr_q [4];
    logic [15:0] ctr_d [4];
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] reg_val;
    logic        sel, accept, ctrl_wr, clear;
    logic        rd_rise, wb_rise;
    logic [3:0]  inc;
    logic        unused_bits;

    assign unused_bits = ^{mem_address[0], mem_wdata[15:2], mem_byte_enable[1]};

    always_comb begin
        sel     = (mem_address[15:4] == BASE_ADDR[15:4]) & (mem_read | mem_write);
        accept  = (state_q == IDLE) & sel;
        // A simultaneous read and write is handled as a store.
        ctrl_wr = accept & mem_write & (mem_address[3:1] == 3'd4) & mem_byte_enable[0];
        clear   = ctrl_wr & mem_wdata[0];
        rd_rise = pmem_read & ~pr_q;
        wb_rise = pmem_write & ~pw_q;
        inc[0]  = rd_rise & cache_read;
        inc[1]  = rd_rise & ~cache_read & cache_write;
        inc[2]  = wb_rise;
        inc[3]  = 1'b1;
    end

    always_comb begin
        reg_val = 16'h0000;
        case (mem_address[3:1])
            3'd0:    reg_val = ctr_q[0];
            3'd1:    reg_val = ctr_q[1];
            3'd2:    reg_val = ctr_q[2];
            3'd3:    reg_val = ctr_q[3];
            3'd4:    reg_val = {14'b0, freeze_q, 1'b0};
            default: reg_val = 16'h0000;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mem_resp = 1'b0;
        case (state_q)
            IDLE: if (sel) state_d = RESP;
            RESP: begin
                mem_resp = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d  = rdata_q;
        freeze_d = freeze_q;
        if (accept && !mem_write) rdata_d = reg_val;
        if (ctrl_wr) freeze_d = mem_wdata[1];
        for (int i = 0; i < 4; i++) begin
            ctr_d[i] = ctr_q[i];
            if (clear) begin
                ctr_d[i] = 16'h0000;
            end else if (!freeze_q && inc[i] && ctr_q[i] != 16'hFFFF) begin
                ctr_d[i] = ctr_q[i] + 16'h0001;
            end
        end
    end

    // Edge registers keep sampling through reset so a strobe held across release is not an edge.
    always_ff @(posedge clk) begin
        pr_q <= pmem_read;
        pw_q <= pmem_write;
        if (reset) begin
            state_q  <= IDLE;
            freeze_q <= 1'b0;
            rdata_q  <= 16'h0000;
            for (int i = 0; i < 4; i++) ctr_q[i] <= 16'h0000;
        end else begin
            state_q  <= state_d;
            freeze_q <= freeze_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < 4; i++) ctr_q[i] <= ctr_d[i];
        end
    end

    assign mem_rdata   = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_perf_counter_mmio.sv
// Directed bench for perf_counter_mmio: scoreboard queue of expected load data,
// immediate-assertion checks sampled on the falling edge.
`timescale 1ns/1ps
module tb_perf_counter_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        cache_read, cache_write, pmem_read, pmem_write;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        dbg_state_o;

  logic [15:0] exp_q[$];
  logic [15:0] last_exp;
  int          passed = 0;
  int          total = 0;

  perf_counter_mmio #(.BASE_ADDR(16'hFF00)) dut (
    .clk(clk), .reset(reset),
    .cache_read(cache_read), .cache_write(cache_write),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a falling edge with the block idle; request accepted at the next rising edge.
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, input logic [15:0] exp, input string tag);
    mem_read = ~we;
    mem_write = we;
    mem_address = addr;
    mem_wdata = wdata;
    mem_byte_enable = be;
    if (!we) exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
    check({tag, "_resp"}, {15'b0, mem_resp}, 16'h0001);
    if (!we) begin
      if (exp_q.size() > 0) begin
        last_exp = exp_q.pop_front();
        check(tag, mem_rdata, last_exp);
      end
    end else begin
      check({tag, "_rdata_kept"}, mem_rdata, last_exp);
    end
    @(negedge clk);
    check({tag, "_resp_drop"}, {15'b0, mem_resp}, 16'h0000);
  endtask

  task automatic load(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    access(1'b0, addr, 16'h0000, 2'b00, exp, tag);
  endtask

  task automatic store(input logic [15:0] addr, input logic [15:0] wdata, input logic [1:0] be,
                       input string tag);
    access(1'b1, addr, wdata, be, 16'h0000, tag);
  endtask

  initial begin
    // Clock/reset block
    reset = 1'b1;
    cache_read = 1'b1; cache_write = 1'b0;
    pmem_read = 1'b0; pmem_write = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    mem_address = 16'h0000; mem_wdata = 16'h0000; mem_byte_enable = 2'b00;
    last_exp = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_resp", {15'b0, mem_resp}, 16'h0000);
    check("rst_rdata", mem_rdata, 16'h0000);
    check("rst_state", {15'b0, dbg_state_o}, 16'h0000);
    reset = 1'b0;

    // 1: two 3-cycle read-miss strobes count as two events
    for (int p = 0; p < 2; p++) begin
      pmem_read = 1'b1;
      repeat (3) @(negedge clk);
      pmem_read = 1'b0;
      repeat (2) @(negedge clk);
    end
    load(16'hFF00, 16'h0002, "t1_ctr0");
    load(16'hFF02, 16'h0000, "t1_ctr1");

    // 2: write misses and writebacks; ignored stores
    cache_read = 1'b0; cache_write = 1'b1;
    for (int p = 0; p < 5; p++) begin
      pmem_read = 1'b1; @(negedge clk);
      pmem_read = 1'b0; @(negedge clk);
    end
    for (int p = 0; p < 2; p++) begin
      pmem_write = 1'b1; repeat (2) @(negedge clk);
      pmem_write = 1'b0; @(negedge clk);
    end
    cache_write = 1'b0;
    load(16'hFF02, 16'h0005, "t2_ctr1");
    load(16'hFF04, 16'h0002, "t2_ctr2");
    load(16'hFF00, 16'h0002, "t2_ctr0");
    store(16'hFF00, 16'h1234, 2'b11, "t2_st_ro");
    load(16'hFF00, 16'h0002, "t2_ctr0_ro");
    store(16'hFF08, 16'h0003, 2'b10, "t2_st_hi_lane");
    load(16'hFF08, 16'h0000, "t2_ctrl_hi_lane");
    load(16'hFF02, 16'h0005, "t2_ctr1_kept");

    // 3: clear, then freeze two cycles later (CTR3 then holds at 2)
    store(16'hFF08, 16'h0001, 2'b01, "t3_clear");
    store(16'hFF08, 16'h0002, 2'b01, "t3_freeze");
    repeat (10) @(negedge clk);
    load(16'hFF06, 16'h0002, "t3_ctr3_a");
    load(16'hFF06, 16'h0002, "t3_ctr3_b");
    load(16'hFF08, 16'h0002, "t3_ctrl");
    store(16'hFF08, 16'h0000, 2'b01, "t3_unfreeze");
    load(16'hFF06, 16'h0003, "t3_ctr3_run");

    // 4: CTR3 runs into saturation and stays there
    repeat (65540) @(negedge clk);
    load(16'hFF06, 16'hFFFF, "t4_sat");
    repeat (3) @(negedge clk);
    load(16'hFF06, 16'hFFFF, "t4_sat_hold");
    load(16'hFF08, 16'h0000, "t4_ctrl");

    // 5: clear in the same cycle as a qualified read-miss edge
    cache_read = 1'b1;
    pmem_read = 1'b1;
    store(16'hFF08, 16'h0001, 2'b01, "t5_clear");
    pmem_read = 1'b0;
    load(16'hFF00, 16'h0000, "t5_ctr0");
    load(16'hFF02, 16'h0000, "t5_ctr1");
    load(16'hFF04, 16'h0000, "t5_ctr2");
    load(16'hFF06, 16'h0007, "t5_ctr3");

    // 6: strobe held through reset release, out-of-window, reserved offsets, reset in RESP
    reset = 1'b1;
    pmem_read = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_exp = 16'h0000;
    repeat (4) @(negedge clk);
    pmem_read = 1'b0;
    @(negedge clk);
    load(16'hFF00, 16'h0000, "t6_ctr0_noedge");
    mem_read = 1'b1; mem_address = 16'hFE00;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    check("t6_oow_resp", {15'b0, mem_resp}, 16'h0000);
    check("t6_oow_state", {15'b0, dbg_state_o}, 16'h0000);
    @(negedge clk);
    check("t6_oow_resp2", {15'b0, mem_resp}, 16'h0000);
    store(16'hFF08, 16'h0002, 2'b01, "t6_freeze");
    load(16'hFF08, 16'h0002, "t6_ctrl");
    store(16'hFF0C, 16'hFFFF, 2'b11, "t6_st_rsvd");
    load(16'hFF0C, 16'h0000, "t6_rsvd_c");
    load(16'hFF08, 16'h0002, "t6_ctrl_b");
    load(16'hFF0A, 16'h0000, "t6_rsvd_a");
    mem_read = 1'b1; mem_address = 16'hFF08;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    reset = 1'b1;
    check("t6_resp_before_rst", {15'b0, mem_resp}, 16'h0001);
    @(posedge clk);
    @(negedge clk);
    check("t6_abort_resp", {15'b0, mem_resp}, 16'h0000);
    check("t6_abort_state", {15'b0, dbg_state_o}, 16'h0000);
    check("t6_abort_rdata", mem_rdata, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    // Final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
